cp0_exception_controller: RTL and testbench

- Sequences exception entry and ERET for coprocessor 0.
- Synchronises external interrupt lines and latches the timer interrupt for Cause.IP/Cause.TI.
- Generates the interrupt request tagged onto the instruction reaching writeback.
- Drives the fetch-redirect handshake toward IF. Sits between the WB stage, the CP0 register file (Status/Cause/EPC/Compare) and IF.

---
 rtl/cp0_exception_controller.sv | 118 +++++++++++
 tb/tb_cp0_exception_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_controller.sv
// CP0 exception/ERET sequencer: interrupt synchronisation, timer latch,
// interrupt request generation and the fetch-redirect handshake toward IF.
module cp0_exception_controller #(
    parameter int unsigned HW_INT_WIDTH     = 6,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [HW_INT_WIDTH-1:0] hardware_interrupt,
    input  logic [7:0]              status_interrupt_mask,
    input  logic                    status_exception_level,
    input  logic                    status_interrupt_enabled,
    input  logic [1:0]              cause_software_interrupt,
    input  logic                    timer_match,
    input  logic                    compare_write,
    input  logic [31:0]             epc_value,
    input  logic                    wb_exception_valid,
    input  logic                    wb_eret,
    input  logic                    flush_ready,
    output logic                    flush_valid,
    output logic [31:0]             flush_address,
    output logic                    controller_busy,
    output logic                    interrupt_request,
    output logic [HW_INT_WIDTH-1:0] cause_hardware_interrupt,
    output logic                    cause_timer_interrupt
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH_EXC,
        FLUSH_ERET
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0][HW_INT_WIDTH-1:0] sync_q;
    logic [5:0] hw_ext;
    logic [7:0] pending;
    logic       irq_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hardware_interrupt};
        end
    end

    assign cause_hardware_interrupt = sync_q[SYNC_STAGES-1];

    // Clear wins over set when Compare is written in the match cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cause_timer_interrupt <= 1'b0;
        end else if (compare_write) begin
            cause_timer_interrupt <= 1'b0;
        end else if (timer_match) begin
            cause_timer_interrupt <= 1'b1;
        end
    end

    assign hw_ext  = 6'(cause_hardware_interrupt);
    assign pending = {hw_ext[5:2] | {cause_timer_interrupt, 3'b000},
                      hw_ext[1:0], cause_software_interrupt};

    always_comb begin
        irq_next = (state == IDLE) && status_interrupt_enabled && !status_exception_level
                   && (|(pending & status_interrupt_mask))
                   && !wb_exception_valid && !wb_eret;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interrupt_request <= 1'b0;
        end else begin
            interrupt_request <= irq_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            flush_valid     <= 1'b0;
            flush_address   <= '0;
            controller_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_exception_valid) begin
                        state           <= FLUSH_EXC;
                        flush_valid     <= 1'b1;
                        controller_busy <= 1'b1;
                        flush_address   <= EXCEPTION_VECTOR;
                    end else if (wb_eret) begin
                        state           <= FLUSH_ERET;
                        flush_valid     <= 1'b1;
                        controller_busy <= 1'b1;
                        flush_address   <= epc_value;
                    end
                end
                FLUSH_EXC, FLUSH_ERET: begin
                    if (flush_ready) begin
                        state           <= IDLE;
                        flush_valid     <= 1'b0;
                        controller_busy <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    flush_valid     <= 1'b0;
                    controller_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exception_controller.sv
// Bench for cp0_exception_controller: directed vector table, reset-abort
// sequence and randomized traffic checked against a cycle-level reference model.
module tb_cp0_exception_controller;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int SYNC = 2;

    logic        clock;
    logic        reset_n;
    logic [5:0]  hardware_interrupt;
    logic [7:0]  status_interrupt_mask;
    logic        status_exception_level;
    logic        status_interrupt_enabled;
    logic [1:0]  cause_software_interrupt;
    logic        timer_match;
    logic        compare_write;
    logic [31:0] epc_value;
    logic        wb_exception_valid;
    logic        wb_eret;
    logic        flush_ready;
    logic        flush_valid;
    logic [31:0] flush_address;
    logic        controller_busy;
    logic        interrupt_request;
    logic [5:0]  cause_hardware_interrupt;
    logic        cause_timer_interrupt;

    cp0_exception_controller #(
        .HW_INT_WIDTH(6),
        .SYNC_STAGES(SYNC),
        .EXCEPTION_VECTOR(VEC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .hardware_interrupt(hardware_interrupt),
        .status_interrupt_mask(status_interrupt_mask),
        .status_exception_level(status_exception_level),
        .status_interrupt_enabled(status_interrupt_enabled),
        .cause_software_interrupt(cause_software_interrupt),
        .timer_match(timer_match),
        .compare_write(compare_write),
        .epc_value(epc_value),
        .wb_exception_valid(wb_exception_valid),
        .wb_eret(wb_eret),
        .flush_ready(flush_ready),
        .flush_valid(flush_valid),
        .flush_address(flush_address),
        .controller_busy(controller_busy),
        .interrupt_request(interrupt_request),
        .cause_hardware_interrupt(cause_hardware_interrupt),
        .cause_timer_interrupt(cause_timer_interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned hw_hist[$];
    logic [5:0]  m_chw;
    logic        m_cti;
    logic        m_irq;
    logic        m_busy;
    logic [31:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hw_hist.delete();
        for (int i = 0; i < SYNC; i++) hw_hist.push_back(0);
        m_chw  = '0;
        m_cti  = 1'b0;
        m_irq  = 1'b0;
        m_busy = 1'b0;
        m_addr = '0;
    endtask

    // Advances the model using the inputs present just before the clock edge.
    task automatic model_update();
        logic        any_int;
        logic        pend_bit;
        logic        n_busy;
        logic [31:0] n_addr;
        any_int = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < 2) pend_bit = cause_software_interrupt[k];
            else       pend_bit = m_chw[k-2];
            if (k == 7) pend_bit = pend_bit | m_cti;
            if (pend_bit && status_interrupt_mask[k]) any_int = 1'b1;
        end
        n_busy = m_busy;
        n_addr = m_addr;
        if (!m_busy) begin
            if (wb_exception_valid) begin n_busy = 1'b1; n_addr = VEC; end
            else if (wb_eret)       begin n_busy = 1'b1; n_addr = epc_value; end
        end else if (flush_ready) begin
            n_busy = 1'b0;
        end
        m_irq = !m_busy && status_interrupt_enabled && !status_exception_level && any_int
                && !wb_exception_valid && !wb_eret;
        if (compare_write)    m_cti = 1'b0;
        else if (timer_match) m_cti = 1'b1;
        hw_hist.push_front(int'(hardware_interrupt));
        void'(hw_hist.pop_back());
        m_chw  = 6'(hw_hist[SYNC-1]);
        m_busy = n_busy;
        m_addr = n_addr;
    endtask

    task automatic compare_model();
        chk("m_flush_valid", {31'b0, flush_valid}, {31'b0, m_busy});
        chk("m_busy", {31'b0, controller_busy}, {31'b0, m_busy});
        chk("m_irq", {31'b0, interrupt_request}, {31'b0, m_irq});
        chk("m_cause_hw", {26'b0, cause_hardware_interrupt}, {26'b0, m_chw});
        chk("m_cause_ti", {31'b0, cause_timer_interrupt}, {31'b0, m_cti});
        if (m_busy) chk("m_flush_addr", flush_address, m_addr);
    endtask

    task automatic step();
        if (wb_exception_valid || wb_eret)
            chk("proto_commit_while_busy", {31'b0, controller_busy}, 32'd0);
        @(posedge clock);
        model_update();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [5:0]  hw;
        logic [7:0]  im;
        logic        exl;
        logic        ie;
        logic [1:0]  sw;
        logic        tm;
        logic        cw;
        logic [31:0] epc;
        logic        exc;
        logic        eret;
        logic        ready;
        logic        e_fv;
        logic [31:0] e_addr;
        logic        e_irq;
        logic [5:0]  e_chw;
        logic        e_cti;
    } vec_t;

    vec_t tbl [31];

    initial begin
        //           hw  im     exl ie sw tm cw epc           exc eret rdy  fv addr          irq chw cti
        tbl[0]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd0, 0};
        tbl[1]  = '{6'd0, 8'h00, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd0, 1};
        tbl[2]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd0, 1};
        tbl[3]  = '{6'd0, 8'h00, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd0, 0};
        tbl[4]  = '{6'd0, 8'h00, 0, 0, 0, 1, 1, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd0, 0};
        tbl[5]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0,  1, VEC,          0, 6'd0, 0};
        tbl[6]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  1, VEC,          0, 6'd0, 0};
        tbl[7]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h0,        0, 6'd0, 0};
        tbl[8]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h80001234, 0, 1, 0,  1, 32'h80001234, 0, 6'd0, 0};
        tbl[9]  = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0,  1, 32'h80001234, 0, 6'd0, 0};
        tbl[10] = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1,  0, 32'h0,        0, 6'd0, 0};
        tbl[11] = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h12345678, 1, 1, 0,  1, VEC,          0, 6'd0, 0};
        tbl[12] = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h0,        0, 6'd0, 0};
        tbl[13] = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h00000040, 0, 1, 0,  1, 32'h00000040, 0, 6'd0, 0};
        tbl[14] = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h0,        0, 6'd0, 0};
        tbl[15] = '{6'd0, 8'h00, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h0,        0, 6'd0, 0};
        tbl[16] = '{6'd4, 8'h10, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd0, 0};
        tbl[17] = '{6'd4, 8'h10, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd4, 0};
        tbl[18] = '{6'd4, 8'h10, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        1, 6'd4, 0};
        tbl[19] = '{6'd4, 8'h10, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd4, 0};
        tbl[20] = '{6'd4, 8'h10, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        1, 6'd4, 0};
        tbl[21] = '{6'd4, 8'h00, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd4, 0};
        tbl[22] = '{6'd4, 8'h80, 0, 1, 0, 1, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd4, 1};
        tbl[23] = '{6'd4, 8'h80, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        1, 6'd4, 1};
        tbl[24] = '{6'd4, 8'h80, 0, 1, 0, 0, 0, 32'h0,        1, 0, 0,  1, VEC,          0, 6'd4, 1};
        tbl[25] = '{6'd4, 8'h80, 0, 1, 0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h0,        0, 6'd4, 1};
        tbl[26] = '{6'd4, 8'h80, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        1, 6'd4, 1};
        tbl[27] = '{6'd4, 8'h80, 0, 1, 0, 0, 1, 32'h0,        0, 0, 0,  0, 32'h0,        1, 6'd4, 0};
        tbl[28] = '{6'd4, 8'h80, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd4, 0};
        tbl[29] = '{6'd4, 8'h01, 0, 1, 1, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        1, 6'd4, 0};
        tbl[30] = '{6'd4, 8'h01, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 6'd4, 0};

        reset_n = 1'b0;
        hardware_interrupt = '0;
        status_interrupt_mask = '0;
        status_exception_level = 1'b0;
        status_interrupt_enabled = 1'b0;
        cause_software_interrupt = '0;
        timer_match = 1'b0;
        compare_write = 1'b0;
        epc_value = '0;
        wb_exception_valid = 1'b0;
        wb_eret = 1'b0;
        flush_ready = 1'b0;
        model_reset();

        #12;
        chk("rst_flush_valid", {31'b0, flush_valid}, 32'd0);
        chk("rst_flush_addr", flush_address, 32'd0);
        chk("rst_busy", {31'b0, controller_busy}, 32'd0);
        chk("rst_irq", {31'b0, interrupt_request}, 32'd0);
        chk("rst_cause_hw", {26'b0, cause_hardware_interrupt}, 32'd0);
        chk("rst_cause_ti", {31'b0, cause_timer_interrupt}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            hardware_interrupt       = tbl[i].hw;
            status_interrupt_mask    = tbl[i].im;
            status_exception_level   = tbl[i].exl;
            status_interrupt_enabled = tbl[i].ie;
            cause_software_interrupt = tbl[i].sw;
            timer_match              = tbl[i].tm;
            compare_write            = tbl[i].cw;
            epc_value                = tbl[i].epc;
            wb_exception_valid       = tbl[i].exc;
            wb_eret                  = tbl[i].eret;
            flush_ready              = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d_flush_valid", i), {31'b0, flush_valid}, {31'b0, tbl[i].e_fv});
            chk($sformatf("tbl%0d_busy", i), {31'b0, controller_busy}, {31'b0, tbl[i].e_fv});
            chk($sformatf("tbl%0d_irq", i), {31'b0, interrupt_request}, {31'b0, tbl[i].e_irq});
            chk($sformatf("tbl%0d_cause_hw", i), {26'b0, cause_hardware_interrupt}, {26'b0, tbl[i].e_chw});
            chk($sformatf("tbl%0d_cause_ti", i), {31'b0, cause_timer_interrupt}, {31'b0, tbl[i].e_cti});
            if (tbl[i].e_fv) chk($sformatf("tbl%0d_flush_addr", i), flush_address, tbl[i].e_addr);
        end

        // Reset while a redirect is pending must drop flush_valid without a clock edge.
        flush_ready = 1'b0;
        wb_exception_valid = 1'b1;
        step();
        wb_exception_valid = 1'b0;
        chk("abort_pre_flush_valid", {31'b0, flush_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_flush_valid", {31'b0, flush_valid}, 32'd0);
        chk("abort_busy", {31'b0, controller_busy}, 32'd0);
        chk("abort_irq", {31'b0, interrupt_request}, 32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;
        flush_ready = 1'b1;
        step();
        flush_ready = 1'b0;
        wb_eret = 1'b1;
        epc_value = 32'hA5A5_0004;
        step();
        wb_eret = 1'b0;
        chk("post_abort_idle_accepts", flush_address, 32'hA5A5_0004);

        for (int n = 0; n < 800; n++) begin
            hardware_interrupt       = 6'($urandom);
            status_interrupt_mask    = 8'($urandom);
            status_exception_level   = ($urandom_range(0, 3) == 0);
            status_interrupt_enabled = ($urandom_range(0, 3) != 0);
            cause_software_interrupt = 2'($urandom);
            timer_match              = ($urandom_range(0, 9) == 0);
            compare_write            = ($urandom_range(0, 9) == 0);
            epc_value                = $urandom;
            flush_ready              = $urandom_range(0, 1) == 1;
            wb_exception_valid       = 1'b0;
            wb_eret                  = 1'b0;
            if (!m_busy) begin
                wb_exception_valid = ($urandom_range(0, 7) == 0);
                wb_eret            = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
